// File: rtl/dez_min.sv
// Tens-of-minutes counter stage of the chronometer.
// The asynchronous carry from the units-of-minutes stage is synchronised and
// edge-detected, then drives a 0..MODULUS-1 counter. The current digit is
// shown on an active-low 7-segment display, and a one-cycle carry is emitted
// on wrap for a later hours stage.
//
// MODULUS must lie in 2..10 and SYNC_STAGES must be at least 2.
//
// Handshake: none. TICK_IN is a level from another clock domain and is
// counted once per rising edge. To be seen reliably it must stay high for at
// least 2 CLK periods, and stay low for at least 2 CLK periods between
// pulses. CLK_OUT is a plain one-cycle strobe with no back-pressure.
module dez_min #(
  parameter int MODULUS     = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       TICK_IN,
  input  logic       CLR,
  input  logic       HOLD,
  output logic [3:0] VALUE,
  output logic       CLK_OUT,
  output logic       ADM,
  output logic       BDM,
  output logic       CDM,
  output logic       DDM,
  output logic       EDM,
  output logic       FDM,
  output logic       GDM
);

  localparam logic [3:0] LAST     = 4'(MODULUS - 1);
  // Segment order in the vector is {a,b,c,d,e,f,g}. A 0 bit lights a segment.
  localparam logic [6:0] SEG_ZERO = 7'b0000001;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   sync_out;
  logic                   tick_rise;
  logic [3:0]             value_q, value_d;
  logic                   carry_q, carry_d;
  logic [6:0]             seg_q, seg_d;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign tick_rise = sync_out & ~edge_q;

  // Synchroniser chain bringing TICK_IN into the CLK domain.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], TICK_IN};
  end

  // The edge flop always follows sync_out, even under HOLD or CLR.
  // As a result, a carry that is still high when HOLD drops is never counted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) edge_q <= 1'b0;
    else        edge_q <= sync_out;
  end

  // Next count and carry. Priority order is CLR, then HOLD, then tick.
  // An out-of-range count, reachable only through an upset, returns to 0
  // on the next tick without raising a carry.
  always_comb begin
    value_d = value_q;
    carry_d = 1'b0;
    if (CLR) begin
      value_d = '0;
    end else if (!HOLD && tick_rise) begin
      if (value_q == LAST) begin
        value_d = '0;
        carry_d = 1'b1;
      end else if (value_q > LAST) begin
        value_d = '0;
      end else begin
        value_d = value_q + 4'd1;
      end
    end
  end

  // Count and carry registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      value_q <= '0;
      carry_q <= 1'b0;
    end else begin
      value_q <= value_d;
      carry_q <= carry_d;
    end
  end

  // 7-segment pattern for the registered count.
  // 6 and 7 include the top bar, and 9 includes the bottom bar.
  // Counts 10..15 blank the display.
  always_comb begin
    seg_d = 7'b1111111;
    case (value_q)
      4'd0:    seg_d = 7'b0000001;
      4'd1:    seg_d = 7'b1001111;
      4'd2:    seg_d = 7'b0010010;
      4'd3:    seg_d = 7'b0000110;
      4'd4:    seg_d = 7'b1001100;
      4'd5:    seg_d = 7'b0100100;
      4'd6:    seg_d = 7'b0100000;
      4'd7:    seg_d = 7'b0001111;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0000100;
      default: seg_d = 7'b1111111;
    endcase
  end

  // Segment register. The display trails VALUE by one cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) seg_q <= SEG_ZERO;
    else        seg_q <= seg_d;
  end

  assign VALUE   = value_q;
  assign CLK_OUT = carry_q;
  assign ADM     = seg_q[6];
  assign BDM     = seg_q[5];
  assign CDM     = seg_q[4];
  assign DDM     = seg_q[3];
  assign EDM     = seg_q[2];
  assign FDM     = seg_q[1];
  assign GDM     = seg_q[0];

endmodule

// File: doc/dez_min.md
Name: dez_min

Overview:
- Tens-of-minutes stage of the chronometer. Sits directly downstream of the units-of-minutes stage and consumes its carry pulse.
- Synchronises the ripple-domain carry into the system clock and counts 0..MODULUS-1.
- Drives one active-low 7-segment digit.
- Emits a single-cycle carry when it wraps, for a future hours stage.

Parameters:
- MODULUS, 6: count range 0..MODULUS-1. Legal values are 2..10.
- SYNC_STAGES, 2: number of flops in the TICK_IN synchroniser. Minimum is 2.

Ports:
- CLK  in  1  system clock; all state is on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- TICK_IN  in  1  carry from units-of-minutes stage. Asynchronous to CLK, high for an arbitrary duration.
- CLR  in  1  synchronous clear of count (active-high).
- HOLD  in  1  pause: freezes the count while high (active-high).
- VALUE  out  4  current tens-of-minutes digit, binary.
- CLK_OUT  out  1  one-cycle pulse on wrap MODULUS-1 -> 0.
- ADM, BDM, CDM, DDM, EDM, FDM, GDM  out  1 each  segments a..g, active-low (0 = lit).

Behaviour:
- Reset: asynchronous on RST_N low, released synchronously by the design flow.
  - Synchroniser flops = 0; edge-detect flop = 0.
  - VALUE = 0; CLK_OUT = 0.
  - Segments show "0": ADM..FDM = 0, GDM = 1.
- Synchroniser and edge detect:
  - TICK_IN passes through SYNC_STAGES flops, then one edge flop.
  - tick_rise = sync_out & ~edge_q.
  - Latency from a TICK_IN rising edge to the VALUE update is SYNC_STAGES+1 CLK cycles (3 with the default).
  - A TICK_IN high level lasting many cycles yields exactly one tick_rise.
  - A TICK_IN pulse shorter than one CLK period may be missed. This is a documented constraint: the upstream pulse must be held at least 2 CLK periods.
- Counter, per cycle, in priority order:
  1. CLR = 1: VALUE <= 0, CLK_OUT <= 0. A coincident tick_rise is discarded.
  2. HOLD = 1: VALUE holds, CLK_OUT <= 0. A coincident tick_rise is discarded, not queued. The edge flop still tracks sync_out, so a carry that is high when HOLD drops does not count.
  3. tick_rise = 1 and VALUE = MODULUS-1: VALUE <= 0, CLK_OUT <= 1 for exactly one cycle.
  4. tick_rise = 1 otherwise: VALUE <= VALUE+1, CLK_OUT <= 0.
  5. Otherwise: hold, CLK_OUT <= 0.
- CLK_OUT is registered and asserts in the same cycle VALUE becomes 0 on a wrap.
- Illegal VALUE (>= MODULUS, reachable only via an SEU): the next tick_rise forces VALUE <= 0 with no CLK_OUT.
- 7-segment decode:
  - Registered, one cycle after VALUE.
  - Standard patterns for 0..9. Digits 6, 7 and 9 use the tails on segments a, a and d respectively.
  - Values 10..15 blank the display (all segments 1).
- Reset mid-operation: RST_N low at any time returns all outputs to reset values immediately, including mid-synchronisation. A pending tick is lost.

Test Plan:
- Reset: RST_N=0 for 3 cycles with TICK_IN toggling -> VALUE=0, CLK_OUT=0, segments {A..G}=0000001. Released with TICK_IN low -> no count.
- Counting: six TICK_IN pulses, each 4 cycles high and 10 cycles low -> VALUE goes 1,2,3,4,5,0.
  - Each update lands 3 cycles after the TICK_IN rise.
  - CLK_OUT is high for exactly 1 cycle on the 5 -> 0 step.
  - Segments for 5 = 0100100, one cycle after VALUE=5.
- Long level: TICK_IN held high for 50 cycles -> VALUE increments by exactly 1, and CLK_OUT stays 0 unless a wrap occurs.
- HOLD: VALUE=3, HOLD=1 across two TICK_IN pulses -> VALUE stays 3 and CLK_OUT stays 0. HOLD=0, then one pulse -> VALUE=4.
- CLR collision: VALUE=5, CLR asserted in the same cycle tick_rise fires -> VALUE=0, CLK_OUT=0. The next pulse gives VALUE=1.
- Async reset mid-sync: a TICK_IN rise followed by RST_N low 1 cycle later, released after 2 cycles -> VALUE=0 and no increment afterward. MODULUS=10 build: 10 pulses -> wrap after 9, with one CLK_OUT.
